// File: rtl/pll_reset_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pll_reset_seq
//
// Power-up and recovery sequencer for the board PLL. Runs in the 50 MHz
// reference domain (clkin). It pulses the PLL reset, waits for the PLL locked
// flag, and releases the downstream system reset only after lock has been
// continuously stable for STABLE_CYCLES. If lock does not arrive within
// LOCK_TIMEOUT the PLL is reset again, up to MAX_RETRY times, after which the
// block parks in a sticky FAIL state until restart or rst_n.
//
// Ports:
//   clkin     in   50 MHz reference clock (same pin as the PLL refclk)
//   rst_n     in   asynchronous active-low reset
//   locked    in   PLL locked flag, asynchronous to clkin
//   restart   in   synchronous level request to restart the whole sequence
//   pll_rst   out  active-high PLL reset
//   sys_rst_n out  active-low reset for downstream clkin-domain logic
//   ready     out  high only in RUN
//   fail      out  high only in FAIL
//   retries   out  lock-timeout retries in the current sequence
//   state     out  debug state code: PLLRST=0 WAIT=1 STABLE=2 RUN=3 FAIL=4
//
// Every output is a flop. Output flops are loaded from the decode of the
// next state, so they change on the same edge as the state register and
// never glitch.
// -----------------------------------------------------------------------------
module pll_reset_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 7
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retries,
  output logic [2:0] state
);

  // One shared counter, sized for the longest interval it has to measure.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  localparam int MAX_CNT = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CW      = $clog2(MAX_CNT) + 1;

  // Terminal counts: the counter starts at 0 on entry to a state, so an
  // interval of N cycles ends when the counter shows N-1.
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_PLLRST = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Lock synchronizer. locked comes from the PLL's own analog lock detector
  // and has no timing relationship to clkin, so it passes through two flops
  // before any decision is made on it. lk_reg is the only copy the FSM sees.
  // ---------------------------------------------------------------------------
  logic lk_meta_reg;
  logic lk_reg;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta_reg <= 1'b0;
      lk_reg      <= 1'b0;
    end else begin
      lk_meta_reg <= locked;
      lk_reg      <= lk_meta_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  state_t          state_reg;
  state_t          state_next;
  logic [CW-1:0]   cnt_reg;
  logic [CW-1:0]   cnt_next;
  logic [3:0]      retries_reg;
  logic [3:0]      retries_next;

  logic            pll_rst_reg;
  logic            sys_rst_n_reg;
  logic            ready_reg;
  logic            fail_reg;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg + CW'(1);
    retries_next = retries_reg;

    if (restart) begin
      // Restart beats every other transition, and while held it keeps the
      // counter pinned at 0 so the reset pulse is timed from its release.
      state_next   = S_PLLRST;
      cnt_next     = '0;
      retries_next = '0;
    end else begin
      unique case (state_reg)
        S_PLLRST: begin
          if (cnt_reg == RST_LAST) begin
            state_next = S_WAIT;
            cnt_next   = '0;
          end
        end

        S_WAIT: begin
          // Lock is tested first so that a lock arriving on the timeout
          // cycle is accepted rather than thrown away by another PLL reset.
          if (lk_reg) begin
            state_next = S_STABLE;
            cnt_next   = '0;
          end else if (cnt_reg == TMO_LAST) begin
            cnt_next = '0;
            if (retries_reg == RETRY_MAX) begin
              state_next = S_FAIL;
            end else begin
              state_next   = S_PLLRST;
              retries_next = retries_reg + 4'd1;
            end
          end
        end

        S_STABLE: begin
          // A single dropout restarts the stability window; it is not a
          // timeout, so the retry count is left alone.
          if (!lk_reg) begin
            state_next = S_WAIT;
            cnt_next   = '0;
          end else if (cnt_reg == STABLE_LAST) begin
            state_next = S_RUN;
            cnt_next   = '0;
          end
        end

        S_RUN: begin
          cnt_next = '0;
          // Losing lock after a good run starts a fresh sequence with a
          // full retry budget.
          if (!lk_reg) begin
            state_next   = S_PLLRST;
            retries_next = '0;
          end
        end

        S_FAIL: begin
          // Sticky: lock events are ignored, only restart/rst_n leave.
          cnt_next = '0;
        end

        default: begin
          state_next   = S_PLLRST;
          cnt_next     = '0;
          retries_next = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State, counter, retry count and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_PLLRST;
      cnt_reg       <= '0;
      retries_reg   <= '0;
      pll_rst_reg   <= 1'b1;
      sys_rst_n_reg <= 1'b0;
      ready_reg     <= 1'b0;
      fail_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      retries_reg   <= retries_next;
      // The PLL is held in reset in PLLRST and FAIL; downstream reset is
      // released only in RUN, which never coincides with pll_rst.
      pll_rst_reg   <= (state_next == S_PLLRST) || (state_next == S_FAIL);
      sys_rst_n_reg <= (state_next == S_RUN);
      ready_reg     <= (state_next == S_RUN);
      fail_reg      <= (state_next == S_FAIL);
    end
  end

  assign pll_rst   = pll_rst_reg;
  assign sys_rst_n = sys_rst_n_reg;
  assign ready     = ready_reg;
  assign fail      = fail_reg;
  assign retries   = retries_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_pll_reset_seq.sv
`timescale 1ns/1ps
// Testbench for pll_reset_seq with RST_CYCLES=4, LOCK_TIMEOUT=20,
// STABLE_CYCLES=8, MAX_RETRY=2. Inputs change on the falling edge of clkin;
// outputs are sampled on the following falling edge, one clkin period after
// the rising edge that acted on them. Expected outputs are pushed to a queue
// when a cycle's stimulus is driven and popped when the sample is taken.
module tb_pll_reset_seq;

  logic       clkin;
  logic       rst_n;
  logic       locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [3:0] retries;
  logic [2:0] state;

  pll_reset_seq #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .MAX_RETRY    (2)
  ) dut (
    .clkin    (clkin),
    .rst_n    (rst_n),
    .locked   (locked),
    .restart  (restart),
    .pll_rst  (pll_rst),
    .sys_rst_n(sys_rst_n),
    .ready    (ready),
    .fail     (fail),
    .retries  (retries),
    .state    (state)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  typedef struct packed {
    logic [2:0] st;
    logic       pr;
    logic       sr;
    logic       rdy;
    logic       fl;
    logic [3:0] rt;
  } exp_t;

  typedef struct {
    logic       lk;
    logic       rs;
    logic [2:0] st;
    logic [3:0] rt;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;

  // Output pattern each state is defined to produce.
  function automatic exp_t mk(input logic [2:0] st, input logic [3:0] rt);
    exp_t e;
    e.st  = st;
    e.pr  = (st == 3'd0) || (st == 3'd4);
    e.sr  = (st == 3'd3);
    e.rdy = (st == 3'd3);
    e.fl  = (st == 3'd4);
    e.rt  = rt;
    return e;
  endfunction

  task automatic compare_pop(input string name);
    exp_t e;
    exp_t got;
    e   = exp_q.pop_front();
    got = '{st: state, pr: pll_rst, sr: sys_rst_n, rdy: ready, fl: fail, rt: retries};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d: got st=%0d pll_rst=%b sys_rst_n=%b ready=%b fail=%b retries=%0d, want st=%0d pll_rst=%b sys_rst_n=%b ready=%b fail=%b retries=%0d",
               name, cyc_no, got.st, got.pr, got.sr, got.rdy, got.fl, got.rt,
               e.st, e.pr, e.sr, e.rdy, e.fl, e.rt);
    end else begin
      $display("ok   %s cyc=%0d st=%0d pll_rst=%b sys_rst_n=%b retries=%0d",
               name, cyc_no, got.st, got.pr, got.sr, got.rt);
    end
  endtask

  // Check the outputs right now, without waiting for a clock edge.
  task automatic check_now(input exp_t e, input string name);
    exp_q.push_back(e);
    compare_pop(name);
  endtask

  // One clock cycle: drive inputs, queue the expectation, sample after the edge.
  task automatic cyc(input logic lk_in, input logic rs, input exp_t e, input string name);
    locked  = lk_in;
    restart = rs;
    exp_q.push_back(e);
    @(posedge clkin);
    @(negedge clkin);
    cyc_no++;
    compare_pop(name);
  endtask

  task automatic run_n(input int n, input logic lk_in, input logic rs,
                       input logic [2:0] st, input logic [3:0] rt, input string name);
    for (int i = 0; i < n; i++) cyc(lk_in, rs, mk(st, rt), name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  vec_t tbl[22];

  initial begin
    // Reset with lock present from the start, then a loss of lock in RUN.
    tbl = '{
      '{1'b1, 1'b0, 3'd0, 4'd0}, '{1'b1, 1'b0, 3'd0, 4'd0}, '{1'b1, 1'b0, 3'd0, 4'd0},
      '{1'b1, 1'b0, 3'd1, 4'd0},
      '{1'b1, 1'b0, 3'd2, 4'd0}, '{1'b1, 1'b0, 3'd2, 4'd0}, '{1'b1, 1'b0, 3'd2, 4'd0},
      '{1'b1, 1'b0, 3'd2, 4'd0}, '{1'b1, 1'b0, 3'd2, 4'd0}, '{1'b1, 1'b0, 3'd2, 4'd0},
      '{1'b1, 1'b0, 3'd2, 4'd0}, '{1'b1, 1'b0, 3'd2, 4'd0},
      '{1'b1, 1'b0, 3'd3, 4'd0}, '{1'b1, 1'b0, 3'd3, 4'd0}, '{1'b1, 1'b0, 3'd3, 4'd0},
      '{1'b0, 1'b0, 3'd3, 4'd0}, '{1'b0, 1'b0, 3'd3, 4'd0},
      '{1'b0, 1'b0, 3'd0, 4'd0}, '{1'b0, 1'b0, 3'd0, 4'd0}, '{1'b0, 1'b0, 3'd0, 4'd0},
      '{1'b0, 1'b0, 3'd0, 4'd0},
      '{1'b0, 1'b0, 3'd1, 4'd0}
    };

    rst_n   = 1'b0;
    locked  = 1'b1;
    restart = 1'b0;
    repeat (3) @(negedge clkin);
    check_now(mk(3'd0, 4'd0), "reset_state");
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++)
      cyc(tbl[i].lk, tbl[i].rs, mk(tbl[i].st, tbl[i].rt), "table");

    // STABLE with a one-cycle dropout after 5 good counts: back to WAIT,
    // then a full fresh window of 8 is needed before RUN.
    run_n(2, 1'b1, 1'b0, 3'd1, 4'd0, "relock_wait");
    run_n(4, 1'b1, 1'b0, 3'd2, 4'd0, "stable_good");
    run_n(1, 1'b0, 1'b0, 3'd2, 4'd0, "stable_drop");
    run_n(1, 1'b1, 1'b0, 3'd2, 4'd0, "stable_drop_sync");
    run_n(1, 1'b1, 1'b0, 3'd1, 4'd0, "stable_to_wait");
    run_n(8, 1'b1, 1'b0, 3'd2, 4'd0, "stable_fresh");
    run_n(2, 1'b1, 1'b0, 3'd3, 4'd0, "run");

    // restart held 10 cycles in RUN, then 4 cycles of PLL reset after release.
    run_n(10, 1'b1, 1'b1, 3'd0, 4'd0, "restart_held");
    run_n(3, 1'b1, 1'b0, 3'd0, 4'd0, "restart_release");
    run_n(1, 1'b1, 1'b0, 3'd1, 4'd0, "restart_wait");
    run_n(1, 1'b1, 1'b0, 3'd2, 4'd0, "restart_stable");

    // Lock lost in STABLE, then three timeouts in WAIT leading to FAIL.
    run_n(2, 1'b0, 1'b0, 3'd2, 4'd0, "unlock_sync");
    for (int r = 0; r < 3; r++) begin
      run_n(20, 1'b0, 1'b0, 3'd1, 4'(r), "timeout_wait");
      if (r < 2) run_n(4, 1'b0, 1'b0, 3'd0, 4'(r + 1), "retry_pllrst");
    end
    run_n(3, 1'b0, 1'b0, 3'd4, 4'd2, "fail");
    run_n(6, 1'b1, 1'b0, 3'd4, 4'd2, "fail_ignores_lock");
    run_n(1, 1'b1, 1'b1, 3'd0, 4'd0, "fail_restart");
    run_n(3, 1'b1, 1'b0, 3'd0, 4'd0, "fail_restart_pllrst");
    run_n(1, 1'b1, 1'b0, 3'd1, 4'd0, "fail_restart_wait");
    run_n(1, 1'b1, 1'b0, 3'd2, 4'd0, "fail_restart_stable");

    // Go to WAIT, then pull rst_n low between clock edges.
    run_n(2, 1'b0, 1'b0, 3'd2, 4'd0, "unlock2_sync");
    run_n(3, 1'b0, 1'b0, 3'd1, 4'd0, "mid_wait");
    #2;
    rst_n = 1'b0;
    #1;
    check_now(mk(3'd0, 4'd0), "async_reset");
    @(negedge clkin);
    check_now(mk(3'd0, 4'd0), "reset_held");
    rst_n = 1'b1;

    // Lock appearing on the timeout cycle wins; then lk falling on the
    // cycle the stability count completes wins too.
    run_n(3, 1'b0, 1'b0, 3'd0, 4'd0, "pllrst2");
    run_n(18, 1'b0, 1'b0, 3'd1, 4'd0, "wait2");
    run_n(2, 1'b1, 1'b0, 3'd1, 4'd0, "wait2_sync");
    run_n(1, 1'b1, 1'b0, 3'd2, 4'd0, "lock_beats_timeout");
    run_n(5, 1'b1, 1'b0, 3'd2, 4'd0, "stable2");
    run_n(2, 1'b0, 1'b0, 3'd2, 4'd0, "stable2_drop_sync");
    run_n(1, 1'b0, 1'b0, 3'd1, 4'd0, "unlock_beats_stable_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
